// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and execute-side outputs of the ID/EX boundary.
// The master drives the ID fields, flush and hold; the slave (the stage) drives the EX fields and stall_out.
interface id_ex_stage_if #(parameter int DW = 32, parameter int RW = 5);
    logic          id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_Branch;
    logic          id_ALUSrc, id_ALUSrc_shamt, id_RegDst;
    logic [3:0]    id_ALUControl;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [RW-1:0] id_rs, id_rt, id_rd, id_shamt;
    logic          flush, hold, stall_out;
    logic          ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_Branch;
    logic          ex_ALUSrc, ex_ALUSrc_shamt;
    logic [3:0]    ex_ALUControl;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [RW-1:0] ex_rs, ex_rt, ex_shamt, ex_wreg;
    modport master (
        output id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_Branch, id_ALUSrc,
               id_ALUSrc_shamt, id_RegDst, id_ALUControl, id_rd1, id_rd2, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_shamt, flush, hold,
        input  stall_out, ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_Branch,
               ex_ALUSrc, ex_ALUSrc_shamt, ex_ALUControl, ex_rd1, ex_rd2, ex_imm, ex_pc4,
               ex_rs, ex_rt, ex_shamt, ex_wreg
    );
    modport slave (
        input  id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_Branch, id_ALUSrc,
               id_ALUSrc_shamt, id_RegDst, id_ALUControl, id_rd1, id_rd2, id_imm, id_pc4,
               id_rs, id_rt, id_rd, id_shamt, flush, hold,
        output stall_out, ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_Branch,
               ex_ALUSrc, ex_ALUSrc_shamt, ex_ALUControl, ex_rd1, ex_rd2, ex_imm, ex_pc4,
               ex_rs, ex_rt, ex_shamt, ex_wreg
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush and hold.
// Defining IDEX_PERF_COUNT_EN adds the bubble_cnt/flush_cnt performance counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IDEX_PERF_COUNT_EN
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt,
`endif
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic          valid, reg_write, memto_reg, mem_write, branch, alu_src, alu_src_shamt;
        logic [3:0]    alu_ctl;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [RW-1:0] rs, rt, shamt, wreg;
    } ex_t;

    ex_t  r_ex, w_cap;
    logic w_hz;

    // An invalid ID slot captures as an all-zero bubble, data included.
    always_comb begin
        w_cap = '0;
        if (bus.id_valid)
            w_cap = ex_t'{valid: 1'b1, reg_write: bus.id_RegWrite, memto_reg: bus.id_MemtoReg,
                          mem_write: bus.id_MemWrite, branch: bus.id_Branch,
                          alu_src: bus.id_ALUSrc, alu_src_shamt: bus.id_ALUSrc_shamt,
                          alu_ctl: bus.id_ALUControl, rd1: bus.id_rd1, rd2: bus.id_rd2,
                          imm: bus.id_imm, pc4: bus.id_pc4, rs: bus.id_rs, rt: bus.id_rt,
                          shamt: bus.id_shamt,
                          wreg: bus.id_RegDst ? bus.id_rd : bus.id_rt};
    end

    assign w_hz = bus.id_valid & r_ex.valid & r_ex.memto_reg & r_ex.reg_write & (|r_ex.wreg)
                & ((r_ex.wreg == bus.id_rs) | (r_ex.wreg == bus.id_rt));

    always_ff @(posedge clk) begin
        if (rst || bus.flush || (!bus.hold && w_hz))
            r_ex <= '0;
        else if (!bus.hold)
            r_ex <= w_cap;
    end

`ifdef IDEX_PERF_COUNT_EN
    logic [31:0] r_bubble_cnt, r_flush_cnt;

    // A flush coinciding with a hazard is charged to the flush counter only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (bus.flush) begin
            r_flush_cnt  <= r_flush_cnt + 32'd1;
        end else if (!bus.hold && w_hz) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

    assign bus.stall_out       = w_hz;
    assign bus.ex_valid        = r_ex.valid;
    assign bus.ex_RegWrite     = r_ex.reg_write;
    assign bus.ex_MemtoReg     = r_ex.memto_reg;
    assign bus.ex_MemWrite     = r_ex.mem_write;
    assign bus.ex_Branch       = r_ex.branch;
    assign bus.ex_ALUSrc       = r_ex.alu_src;
    assign bus.ex_ALUSrc_shamt = r_ex.alu_src_shamt;
    assign bus.ex_ALUControl   = r_ex.alu_ctl;
    assign bus.ex_rd1          = r_ex.rd1;
    assign bus.ex_rd2          = r_ex.rd2;
    assign bus.ex_imm          = r_ex.imm;
    assign bus.ex_pc4          = r_ex.pc4;
    assign bus.ex_rs           = r_ex.rs;
    assign bus.ex_rt           = r_ex.rt;
    assign bus.ex_shamt        = r_ex.shamt;
    assign bus.ex_wreg         = r_ex.wreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus random stimulus; expected EX state and stall are queued per cycle
// from an instruction-level model and checked by an independent monitor at the falling edge.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

`ifdef IDEX_PERF_COUNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
    id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bubble_cnt(bubble_cnt),
                                        .flush_cnt(flush_cnt), .bus(bus.slave));
`else
    id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

    typedef struct packed {
        logic        valid, rw, m2r, mw, br, alus, aluss, rdst;
        logic [3:0]  alu;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd, shamt;
    } id_t;

    typedef struct packed {
        logic        valid, rw, m2r, mw, br, alus, aluss;
        logic [3:0]  alu;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, shamt, wreg;
    } ex_t;

    typedef struct packed {
        ex_t         ex;
        logic        stall;
        logic [31:0] bub, fl;
    } exp_t;

    exp_t        sb[$];
    ex_t         m_ex;
    logic [31:0] m_bub, m_fl;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ex_t capture(input id_t x);
        ex_t e = '0;
        if (x.valid) begin
            e.valid = 1'b1; e.rw = x.rw; e.m2r = x.m2r; e.mw = x.mw; e.br = x.br;
            e.alus = x.alus; e.aluss = x.aluss; e.alu = x.alu;
            e.rd1 = x.rd1; e.rd2 = x.rd2; e.imm = x.imm; e.pc4 = x.pc4;
            e.rs = x.rs; e.rt = x.rt; e.shamt = x.shamt;
            e.wreg = x.rdst ? x.rd : x.rt;
        end
        return e;
    endfunction

    // A load in EX whose nonzero target is read by the ID instruction.
    function automatic logic load_use(input ex_t e, input id_t x);
        return x.valid && e.valid && e.m2r && e.rw && e.wreg != 5'd0
            && (e.wreg == x.rs || e.wreg == x.rt);
    endfunction

    function automatic id_t rand_id();
        id_t x = '0;
        int  kind = $urandom_range(0, 3);
        x.valid = $urandom_range(0, 7) != 0;
        x.rw    = kind == 0 || kind == 2;
        x.m2r   = kind == 0;
        x.mw    = kind == 1;
        x.br    = kind == 3;
        x.alus  = kind <= 1;
        x.rdst  = kind == 2;
        x.aluss = 1'($urandom_range(0, 1));
        x.alu   = 4'($urandom_range(0, 15));
        x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
        x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 3)); x.shamt = 5'($urandom_range(0, 31));
        return x;
    endfunction

    task automatic drive(input id_t x, input logic f, input logic h, input logic r);
        bus.id_valid = x.valid; bus.id_RegWrite = x.rw; bus.id_MemtoReg = x.m2r;
        bus.id_MemWrite = x.mw; bus.id_Branch = x.br; bus.id_ALUSrc = x.alus;
        bus.id_ALUSrc_shamt = x.aluss; bus.id_RegDst = x.rdst; bus.id_ALUControl = x.alu;
        bus.id_rd1 = x.rd1; bus.id_rd2 = x.rd2; bus.id_imm = x.imm; bus.id_pc4 = x.pc4;
        bus.id_rs = x.rs; bus.id_rt = x.rt; bus.id_rd = x.rd; bus.id_shamt = x.shamt;
        bus.flush = f; bus.hold = h; rst = r;
    endtask

    // One cycle: present inputs, queue what the DUT must show before the edge, then advance the model.
    task automatic step(input id_t x, input logic f, input logic h, input logic r);
        logic hz;
        drive(x, f, h, r);
        hz = load_use(m_ex, x);
        sb.push_back(exp_t'{ex: m_ex, stall: hz, bub: m_bub, fl: m_fl});
        @(posedge clk);
        if (r) begin
            m_ex = '0; m_bub = 0; m_fl = 0;
        end else if (f) begin
            m_ex = '0; m_fl = m_fl + 1;
        end else if (!h) begin
            if (hz) begin
                m_ex = '0; m_bub = m_bub + 1;
            end else begin
                m_ex = capture(x);
            end
        end
        #1;
    endtask

    function automatic logic [191:0] outs();
        return {bus.ex_valid, bus.ex_RegWrite, bus.ex_MemtoReg, bus.ex_MemWrite, bus.ex_Branch,
                bus.ex_ALUSrc, bus.ex_ALUSrc_shamt, bus.ex_ALUControl, bus.ex_rd1, bus.ex_rd2,
                bus.ex_imm, bus.ex_pc4, bus.ex_rs, bus.ex_rt, bus.ex_shamt, bus.ex_wreg};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_out", 192'(bus.stall_out), 192'(e.stall));
                chk("ex_valid", 192'(bus.ex_valid), 192'(e.ex.valid));
                chk("ex_ctrl", 192'({bus.ex_RegWrite, bus.ex_MemtoReg, bus.ex_MemWrite,
                    bus.ex_Branch, bus.ex_ALUSrc, bus.ex_ALUSrc_shamt, bus.ex_ALUControl}),
                    192'({e.ex.rw, e.ex.m2r, e.ex.mw, e.ex.br, e.ex.alus, e.ex.aluss, e.ex.alu}));
                chk("ex_data", 192'({bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc4, bus.ex_rs,
                    bus.ex_rt, bus.ex_shamt, bus.ex_wreg}),
                    192'({e.ex.rd1, e.ex.rd2, e.ex.imm, e.ex.pc4, e.ex.rs, e.ex.rt,
                    e.ex.shamt, e.ex.wreg}));
`ifdef IDEX_PERF_COUNT_EN
                chk("bubble_cnt", 192'(bubble_cnt), 192'(e.bub));
                chk("flush_cnt", 192'(flush_cnt), 192'(e.fl));
`endif
            end
        end
    end

    initial begin
        id_t          x;
        logic [191:0] snap;
        logic         keep;
        drive(rand_id(), 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        m_ex = '0; m_bub = 0; m_fl = 0;
        step(rand_id(), 1'b1, 1'b0, 1'b1);
        step(rand_id(), 1'b0, 1'b1, 1'b1);

        x = '0; x.valid = 1; x.rw = 1; x.alus = 1; x.rt = 9; x.imm = 32'h10; x.alu = 4'b0010;
        step(x, 1'b0, 1'b0, 1'b0);
        chk("addi_wreg", 192'(bus.ex_wreg), 192'(9));
        chk("addi_alu", 192'(bus.ex_ALUControl), 192'(2));
        chk("addi_imm", 192'(bus.ex_imm), 192'(32'h10));
        chk("addi_valid", 192'(bus.ex_valid), 192'(1));

        x = '0; x.valid = 1; x.rw = 1; x.m2r = 1; x.alus = 1; x.rs = 1; x.rt = 8;
        step(x, 1'b0, 1'b0, 1'b0);
        x = '0; x.valid = 1; x.rw = 1; x.rdst = 1; x.rs = 8; x.rt = 2; x.rd = 3;
        chk("lu_stall_hi", 192'(load_use(m_ex, x)), 192'(1));
        step(x, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble_valid", 192'(bus.ex_valid), 192'(0));
        chk("lu_bubble_rw", 192'(bus.ex_RegWrite), 192'(0));
        step(x, 1'b0, 1'b0, 1'b0);
        chk("lu_add_valid", 192'(bus.ex_valid), 192'(1));
        chk("lu_add_wreg", 192'(bus.ex_wreg), 192'(3));

        x = '0; x.valid = 1; x.rw = 1; x.m2r = 1; x.alus = 1; x.rt = 0;
        step(x, 1'b0, 1'b0, 1'b0);
        x = '0; x.valid = 1; x.rw = 1; x.rdst = 1; x.rs = 0; x.rt = 0; x.rd = 4;
        step(x, 1'b0, 1'b0, 1'b0);
        chk("lw0_no_bubble", 192'(bus.ex_valid), 192'(1));
        x = '0; x.valid = 1; x.mw = 1; x.alus = 1; x.rs = 1; x.rt = 5;
        step(x, 1'b0, 1'b0, 1'b0);
        x = '0; x.valid = 1; x.rw = 1; x.rdst = 1; x.rs = 5; x.rt = 5; x.rd = 6;
        step(x, 1'b0, 1'b0, 1'b0);
        chk("sw_no_bubble", 192'(bus.ex_valid), 192'(1));

        x = '0; x.valid = 1; x.rw = 1; x.m2r = 1; x.alus = 1; x.rt = 7;
        step(x, 1'b0, 1'b0, 1'b0);
        x = '0; x.valid = 1; x.rw = 1; x.rdst = 1; x.rs = 7; x.rd = 2;
        step(x, 1'b1, 1'b1, 1'b0);
        chk("flush_prio_valid", 192'(bus.ex_valid), 192'(0));

        x = '0; x.valid = 1; x.rw = 1; x.alus = 1; x.rt = 3; x.imm = 32'h1234;
        step(x, 1'b0, 1'b0, 1'b0);
        snap = outs();
        for (int i = 0; i < 3; i++) begin
            step(rand_id(), 1'b0, 1'b1, 1'b0);
            chk("hold_stable", outs(), snap);
        end
        x = rand_id(); x.valid = 1;
        step(x, 1'b0, 1'b0, 1'b0);
        chk("hold_release_imm", 192'(bus.ex_imm), 192'(x.imm));

        keep = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic f, h, r;
            if (!keep) x = rand_id();
            f = $urandom_range(0, 9) == 0;
            h = $urandom_range(0, 7) == 0;
            r = $urandom_range(0, 99) == 0;
            keep = !r && !f && (h || load_use(m_ex, x));
            step(x, f, h, r);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 192'(sb.size()), 192'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
